// File: rtl/mips_pkg.sv
// Shared constants for the MIPS core front end.
//   ADDR_W    : PC / address width in bits
//   RESET_PC  : PC value loaded at reset
//   NOP_INSTR : encoding placed in IF/ID on reset or flush (sll $0,$0,0)
//   PC_STEP   : byte distance between sequential instructions
package mips_pkg;

  localparam int          ADDR_W    = 32;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam int          PC_STEP   = 4;

endpackage : mips_pkg

// File: rtl/if_stage_pc_ctrl_pc_incr.sv
// PC incrementor: purely combinational, out = in + PC_STEP (modulo 2^W).
// Ports:
//   i_pc   in  W  current program counter
//   o_pc4  out W  program counter plus one instruction
module if_stage_pc_ctrl_pc_incr
  import mips_pkg::*;
#(
  parameter int W = ADDR_W
) (
  input  logic [W-1:0] i_pc,
  output logic [W-1:0] o_pc4
);

  // Carry out of the top bit is dropped on purpose, so the PC wraps silently.
  assign o_pc4 = i_pc + W'(PC_STEP);

endmodule : if_stage_pc_ctrl_pc_incr

// File: rtl/if_stage_pc_ctrl.sv
// Instruction-fetch front end: owns the PC, selects the next PC
// (sequential / branch / jump), and holds the IF/ID pipeline register.
// Ports:
//   clk              in   1       core clock, rising edge
//   rst_n            in   1       synchronous reset, active-low
//   stall_i          in   1       hold PC and IF/ID this cycle
//   branch_taken_i   in   1       branch resolved taken (highest priority)
//   branch_target_i  in   ADDR_W  branch target address
//   jump_i           in   1       j/jal decoded
//   jump_target_i    in   ADDR_W  jump target address
//   instr_i          in   32      instruction memory read data at pc_o
//   pc_o             out  ADDR_W  current PC / instruction memory address
//   if_id_pc4_o      out  ADDR_W  IF/ID: PC+4 of held instruction
//   if_id_instr_o    out  32      IF/ID: held instruction
//   if_id_valid_o    out  1       IF/ID: 1 = real instruction, 0 = bubble
module if_stage_pc_ctrl
  import mips_pkg::*;
#(
  parameter int                ADDR_W    = mips_pkg::ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC  = mips_pkg::RESET_PC,
  parameter logic [31:0]       NOP_INSTR = mips_pkg::NOP_INSTR
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall_i,
  input  logic              branch_taken_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  input  logic              jump_i,
  input  logic [ADDR_W-1:0] jump_target_i,
  input  logic [31:0]       instr_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic [ADDR_W-1:0] if_id_pc4_o,
  output logic [31:0]       if_id_instr_o,
  output logic              if_id_valid_o
);

  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_if_id_pc4;
  logic [31:0]       r_if_id_instr;
  logic              r_if_id_valid;

  logic [ADDR_W-1:0] w_pc4;
  logic [ADDR_W-1:0] w_branch_pc;
  logic [ADDR_W-1:0] w_jump_pc;

  if_stage_pc_ctrl_pc_incr #(
    .W (ADDR_W)
  ) u_pc_incr (
    .i_pc  (r_pc),
    .o_pc4 (w_pc4)
  );

  // Targets are word-aligned on load so pc_o[1:0] can never become non-zero.
  assign w_branch_pc = branch_target_i & ALIGN_MASK;
  assign w_jump_pc   = jump_target_i   & ALIGN_MASK;

  // Reset is tested first so X on the control inputs cannot disturb reset values.
  // Redirects are tested before stall_i: a taken branch or jump must never be
  // lost to a stall, and it always leaves exactly one bubble in IF/ID.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values of the others, matching real flip-flops.
    if (!rst_n) begin
      r_pc          <= RESET_PC;
      r_if_id_pc4   <= '0;
      r_if_id_instr <= NOP_INSTR;
      r_if_id_valid <= 1'b0;
    end else if (branch_taken_i) begin
      r_pc          <= w_branch_pc;
      r_if_id_pc4   <= '0;
      r_if_id_instr <= NOP_INSTR;
      r_if_id_valid <= 1'b0;
    end else if (jump_i) begin
      r_pc          <= w_jump_pc;
      r_if_id_pc4   <= '0;
      r_if_id_instr <= NOP_INSTR;
      r_if_id_valid <= 1'b0;
    end else if (!stall_i) begin
      r_pc          <= w_pc4;
      r_if_id_pc4   <= w_pc4;
      r_if_id_instr <= instr_i;
      r_if_id_valid <= 1'b1;
    end
    // Stall: no assignment, every register holds.
  end

  assign pc_o          = r_pc;
  assign if_id_pc4_o   = r_if_id_pc4;
  assign if_id_instr_o = r_if_id_instr;
  assign if_id_valid_o = r_if_id_valid;

endmodule : if_stage_pc_ctrl

// File: tb/tb_if_stage_pc_ctrl.sv
// Self-checking bench for if_stage_pc_ctrl. A behavioural model predicts the
// registered outputs for each directed step; predictions are queued when the
// step is driven and popped/compared after the clock edge.
module tb_if_stage_pc_ctrl;

  logic        clk;
  logic        rst_n;
  logic        stall_i;
  logic        branch_taken_i;
  logic [31:0] branch_target_i;
  logic        jump_i;
  logic [31:0] jump_target_i;
  logic [31:0] instr_i;
  logic [31:0] pc_o;
  logic [31:0] if_id_pc4_o;
  logic [31:0] if_id_instr_o;
  logic        if_id_valid_o;

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] instr;
    logic        valid;
  } exp_t;

  exp_t sb_q[$];

  int total = 0;
  int bad   = 0;

  // Bench-side model state.
  logic [31:0] m_pc;
  logic [31:0] m_pc4;
  logic [31:0] m_instr;
  logic        m_valid;

  if_stage_pc_ctrl dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .stall_i         (stall_i),
    .branch_taken_i  (branch_taken_i),
    .branch_target_i (branch_target_i),
    .jump_i          (jump_i),
    .jump_target_i   (jump_target_i),
    .instr_i         (instr_i),
    .pc_o            (pc_o),
    .if_id_pc4_o     (if_id_pc4_o),
    .if_id_instr_o   (if_id_instr_o),
    .if_id_valid_o   (if_id_valid_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory contents: address 0 holds addi $1,$0,5; every other
  // word holds a pattern derived from its address.
  function automatic logic [31:0] imem(input logic [31:0] a);
    if (a == 32'h0) return 32'h2001_0005;
    return {a[15:0] ^ 16'hA5A5, a[15:0]};
  endfunction

  always_comb instr_i = imem(pc_o);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Drive one cycle of inputs, predict the post-edge outputs, then compare.
  task automatic step(input string tag, input logic rn, input logic st,
                      input logic br, input logic [31:0] bt,
                      input logic jp, input logic [31:0] jt);
    exp_t e;
    rst_n           = rn;
    stall_i         = st;
    branch_taken_i  = br;
    branch_target_i = bt;
    jump_i          = jp;
    jump_target_i   = jt;
    if (!rn) begin
      m_pc = 32'h0; m_pc4 = 32'h0; m_instr = 32'h0; m_valid = 1'b0;
    end else if (br) begin
      m_pc = {bt[31:2], 2'b00}; m_pc4 = 32'h0; m_instr = 32'h0; m_valid = 1'b0;
    end else if (jp) begin
      m_pc = {jt[31:2], 2'b00}; m_pc4 = 32'h0; m_instr = 32'h0; m_valid = 1'b0;
    end else if (!st) begin
      m_instr = imem(m_pc);
      m_pc    = m_pc + 32'd4;
      m_pc4   = m_pc;
      m_valid = 1'b1;
    end
    e.tag = tag; e.pc = m_pc; e.pc4 = m_pc4; e.instr = m_instr; e.valid = m_valid;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check({e.tag, ".pc"},    pc_o,          e.pc);
    check({e.tag, ".pc4"},   if_id_pc4_o,   e.pc4);
    check({e.tag, ".instr"}, if_id_instr_o, e.instr);
    check({e.tag, ".valid"}, {31'h0, if_id_valid_o}, {31'h0, e.valid});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "timeout");
  end

  initial begin
    m_pc = 32'h0; m_pc4 = 32'h0; m_instr = 32'h0; m_valid = 1'b0;
    rst_n = 1'b0; stall_i = 1'b0; branch_taken_i = 1'b0; jump_i = 1'b0;
    branch_target_i = 32'h0; jump_target_i = 32'h0;
    @(negedge clk);

    // 1: reset for two edges with random control and target inputs.
    step("rst0", 1'b0, 1'($urandom), 1'($urandom), $urandom, 1'($urandom), $urandom);
    step("rst1", 1'b0, 1'($urandom), 1'($urandom), $urandom, 1'($urandom), $urandom);
    check("rst.pc_lit", pc_o, 32'h0);

    // 2: sequential fetch from address 0.
    step("seq0", 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    check("seq0.instr_lit", if_id_instr_o, 32'h2001_0005);
    check("seq0.pc_lit",    pc_o,          32'h4);
    step("seq1", 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);

    // 3: stall at pc 8 for two edges, then release.
    check("stall.pre_pc", pc_o, 32'h8);
    step("stall0", 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    step("stall1", 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    check("stall.hold_pc", pc_o, 32'h8);
    step("stall_rel", 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    check("stall_rel.pc_lit", pc_o, 32'hC);

    // 4: branch beats jump and stall, one bubble, then target fetched.
    step("br_prio", 1'b1, 1'b1, 1'b1, 32'h40, 1'b1, 32'h80);
    check("br_prio.pc_lit", pc_o, 32'h40);
    step("br_next", 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    check("br_next.pc4_lit", if_id_pc4_o, 32'h44);

    // Jump beats stall.
    step("jp_stall", 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h200);

    // 5: misaligned jump target is word-aligned, one bubble.
    step("jp_mis", 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0103);
    check("jp_mis.pc_lit", pc_o, 32'h0000_0100);
    step("jp_next", 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);

    // 6: wrap past the top of the address space, then reset mid-stall.
    step("wrap_br", 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 32'h0);
    check("wrap_br.pc_lit", pc_o, 32'hFFFF_FFFC);
    step("wrap_seq", 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    check("wrap_seq.pc_lit", pc_o, 32'h0);
    step("wrap_seq2", 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    step("rst_stall", 1'b0, 1'b1, 1'b1, 32'h300, 1'b1, 32'h400);
    step("post_rst", 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_if_stage_pc_ctrl
